auth_ctrl_param: RTL and testbench
==================================

Name: auth_ctrl_param

Overview:
Parametrised successor to the current two-stage (player ID, then password) login block, merged into one FSM. Adds configurable ID and password lengths, a configurable player count, a failed-attempt lockout, and a password-entry inactivity timeout. Sits between the keypad/switch front end (debounced one-cycle `user_load` pulses) and the game controller. Its outputs gate game start and select the player's score slot.

Parameters:
DIGIT_W, 4, width of one entered digit
ID_DIGITS, 2, digits per player ID
PSWD_DIGITS, 4, digits per password
NUM_PLAYERS, 4, registered players (guest excluded)
PID_W, 3, player_id width; must be ≥ clog2(NUM_PLAYERS+1)
MAX_TRIES, 3, consecutive failures before lockout
LOCK_CYCLES, 500, lockout duration in clk cycles
TIMEOUT_CYCLES, 1000, idle cycles allowed in password entry

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
user_digit  in  DIGIT_W  digit value, sampled when user_load=1
user_load  in  1  one-cycle digit-enter strobe
logout_req  in  1  logout request from game controller
logged_in  out  1  session active
player_id  out  PID_W  1..NUM_PLAYERS for a player, 0 for guest or none
is_guest  out  1  guest session active
id_correct  out  1  ID matched, password entry in progress
locked_out  out  1  lockout active
fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failures, for display

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, the FSM goes to ENTER_ID, and the digit buffer and all counters clear. Reset applies at any point, including mid-entry or during lockout.
- Digit entry:
  - Digits shift in most-significant first.
  - A digit counter counts `user_load` pulses.
  - `user_load` is ignored in CHECK_ID, CHECK_PW, LOGGED_IN and LOCKED.
- States:
  - ENTER_ID: on the ID_DIGITS-th load, go to CHECK_ID.
  - CHECK_ID (1 cycle):
    - ID all zeros → LOGGED_IN with is_guest=1 and player_id=0.
    - ID matches player k → ENTER_PW with id_correct=1 and internal k latched.
    - Otherwise → ENTER_ID with fail_cnt+1.
  - ENTER_PW:
    - On the PSWD_DIGITS-th load, go to CHECK_PW.
    - An idle counter resets on every load. When it reaches TIMEOUT_CYCLES, go to ENTER_ID and clear id_correct. A timeout is not counted as a failure.
  - CHECK_PW (1 cycle):
    - Match with player k's password → LOGGED_IN with player_id=k and fail_cnt cleared.
    - Otherwise → ENTER_ID with id_correct cleared and fail_cnt+1.
  - LOGGED_IN: on logout_req, go to ENTER_ID the next cycle. logged_in, is_guest, player_id and id_correct clear, and the digit buffer clears.
  - LOCKED: entered instead of ENTER_ID when an increment brings fail_cnt to MAX_TRIES.
    - locked_out=1 while here.
    - After exactly LOCK_CYCLES cycles, go to ENTER_ID with fail_cnt=0.
- Latency: with the last digit loaded in cycle t, the outputs are valid and registered in cycle t+2.
- Output timing: all outputs are registered, with no combinational path from inputs.
- Guest login never increments or clears fail_cnt.
- logout_req outside LOGGED_IN is ignored.
- user_load and a timeout in the same cycle: the load wins and the idle counter resets.

Decomposition:
- Package `auth_pkg`:
  - state enum;
  - credential constants: player k's ID is k zero-padded, so player 1 is 0,1;
  - passwords P1=1,2,3,4; P2=5,6,7,8; P3=9,0,1,2; P4=3,4,5,6;
  - GUEST_ID=0.
- Sub-module `auth_cred_rom`:
  - combinational lookup;
  - inputs: ID buffer and player index;
  - outputs: id_hit, hit_index, pswd_match.

Test Plan:
- Load 0,1 then 1,2,3,4 → id_correct=1 two cycles after the second digit; then logged_in=1, player_id=1, is_guest=0, fail_cnt=0.
- Load 0,0 → logged_in=1, is_guest=1, player_id=0, id_correct never 1.
- Enter ID 0,2 with wrong password 1,1,1,1 three times → fail_cnt goes 1, 2; on the third failure locked_out=1 for 500 cycles, loads are ignored meanwhile, then fail_cnt=0 and ID entry works again.
- Load 0,3 then 9,0 and idle 1000 cycles → id_correct drops to 0, fail_cnt unchanged; a fresh 0,3 and 9,0,1,2 → player_id=3.
- Logged in as 4 (0,4 then 3,4,5,6), pulse logout_req → next cycle all outputs 0; a digit loaded the same cycle is ignored.
- Assert rst low mid-password (0,1 then 1,2) → outputs clear immediately; after release, 0,1 then 1,2,3,4 logs in normally.

Source files
------------

// File: rtl/auth_ctrl_param_pkg.sv
// auth_pkg: FSM states and credential tables for the parametrised login controller.
package auth_pkg;
  typedef enum logic [2:0] {ENTER_ID, CHECK_ID, ENTER_PW, CHECK_PW, LOGGED_IN, LOCKED} state_t;
  localparam int GUEST_ID = 0;
  localparam int PSWD_STRIDE = 4;
  // Player k's ID is k in decimal, zero-padded; digit 0 is the most significant.
  function automatic int id_digit(input int k, input int i, input int n);
    int v;
    v = k;
    for (int j = 0; j < n - 1 - i; j++) v = v / 10;
    return v % 10;
  endfunction
  // Passwords run 1,2,3,4 / 5,6,7,8 / 9,0,1,2 / 3,4,5,6 ... modulo 10.
  function automatic int pswd_digit(input int k, input int i);
    return ((k - 1) * PSWD_STRIDE + i + 1) % 10;
  endfunction
endpackage

// File: rtl/auth_ctrl_param_if.sv
// auth_ctrl_param_if: keypad-side inputs and session outputs of the login controller.
interface auth_ctrl_param_if #(
  parameter int DIGIT_W = 4,
  parameter int PID_W = 3,
  parameter int FAIL_W = 2
);
  logic [DIGIT_W-1:0] user_digit;
  logic user_load;
  logic logout_req;
  logic logged_in;
  logic [PID_W-1:0] player_id;
  logic is_guest;
  logic id_correct;
  logic locked_out;
  logic [FAIL_W-1:0] fail_cnt;
  modport master (
    output user_digit, user_load, logout_req,
    input logged_in, player_id, is_guest, id_correct, locked_out, fail_cnt
  );
  modport slave (
    input user_digit, user_load, logout_req,
    output logged_in, player_id, is_guest, id_correct, locked_out, fail_cnt
  );
endinterface

// File: rtl/auth_ctrl_param_cred_rom.sv
// auth_cred_rom: combinational ID lookup and password compare against the credential table.
module auth_cred_rom
  import auth_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int ID_DIGITS = 2,
  parameter int PSWD_DIGITS = 4,
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W = 3,
  parameter int BUF_W = 16
) (
  input  logic [BUF_W-1:0] buf_q,
  input  logic [PID_W-1:0] idx,
  output logic id_hit,
  output logic [PID_W-1:0] hit_index,
  output logic pswd_match
);
  localparam int ID_W = ID_DIGITS * DIGIT_W;
  localparam int PW_W = PSWD_DIGITS * DIGIT_W;
  logic [NUM_PLAYERS-1:0] id_m, pw_m;
  for (genvar k = 1; k <= NUM_PLAYERS; k++) begin : g_pl
    logic [ID_W-1:0] id_k;
    logic [PW_W-1:0] pw_k;
    for (genvar i = 0; i < ID_DIGITS; i++) begin : g_id
      assign id_k[(ID_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = DIGIT_W'(id_digit(k, i, ID_DIGITS));
    end
    for (genvar i = 0; i < PSWD_DIGITS; i++) begin : g_pw
      assign pw_k[(PSWD_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = DIGIT_W'(pswd_digit(k, i));
    end
    assign id_m[k-1] = buf_q[ID_W-1:0] == id_k;
    assign pw_m[k-1] = buf_q[PW_W-1:0] == pw_k;
  end
  always_comb begin
    id_hit = 1'b0;
    hit_index = '0;
    pswd_match = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (id_m[k] && !id_hit) begin
        id_hit = 1'b1;
        hit_index = PID_W'(k + 1);
      end
      if (idx == PID_W'(k + 1)) pswd_match = pw_m[k];
    end
  end
endmodule

// File: rtl/auth_ctrl_param.sv
// auth_ctrl_param: single-FSM ID + password login with lockout and password-entry timeout.
module auth_ctrl_param
  import auth_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int ID_DIGITS = 2,
  parameter int PSWD_DIGITS = 4,
  parameter int NUM_PLAYERS = 4,
  parameter int PID_W = 3,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  auth_ctrl_param_if.slave bus
);
  localparam int FCW = $clog2(MAX_TRIES + 1);
  localparam int BUF_D = ID_DIGITS > PSWD_DIGITS ? ID_DIGITS : PSWD_DIGITS;
  localparam int BUF_W = BUF_D * DIGIT_W;
  localparam int ID_W = ID_DIGITS * DIGIT_W;
  localparam int DCW = $clog2(BUF_D + 1);
  localparam int TMAX = LOCK_CYCLES > TIMEOUT_CYCLES ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  state_t st, st_n;
  logic [BUF_W-1:0] dbuf, dbuf_n;
  logic [DCW-1:0] dcnt, dcnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [PID_W-1:0] idx, idx_n, pid, pid_n, hit_index;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic li, li_n, gst, gst_n, idc, idc_n, lck, lck_n;
  logic load, fail, id_hit, pswd_match;
  assign load = bus.user_load && (st == ENTER_ID || st == ENTER_PW);
  auth_cred_rom #(
    .DIGIT_W(DIGIT_W), .ID_DIGITS(ID_DIGITS), .PSWD_DIGITS(PSWD_DIGITS),
    .NUM_PLAYERS(NUM_PLAYERS), .PID_W(PID_W), .BUF_W(BUF_W)
  ) u_rom (
    .buf_q(dbuf), .idx(idx), .id_hit(id_hit), .hit_index(hit_index), .pswd_match(pswd_match)
  );
  always_comb begin
    st_n = st;
    dbuf_n = load ? {dbuf[BUF_W-DIGIT_W-1:0], bus.user_digit} : dbuf;
    dcnt_n = load ? dcnt + DCW'(1) : dcnt;
    tmr_n = '0;
    idx_n = idx;
    pid_n = pid;
    fcnt_n = fcnt;
    li_n = li;
    gst_n = gst;
    idc_n = idc;
    lck_n = lck;
    fail = 1'b0;
    case (st)
      ENTER_ID: if (load && dcnt == DCW'(ID_DIGITS - 1)) begin
        st_n = CHECK_ID;
        dcnt_n = '0;
      end
      CHECK_ID: begin
        dbuf_n = '0;
        if (dbuf[ID_W-1:0] == '0) begin
          st_n = LOGGED_IN;
          li_n = 1'b1;
          gst_n = 1'b1;
          pid_n = PID_W'(GUEST_ID);
        end else if (id_hit) begin
          st_n = ENTER_PW;
          idc_n = 1'b1;
          idx_n = hit_index;
        end else fail = 1'b1;
      end
      ENTER_PW: if (load && dcnt == DCW'(PSWD_DIGITS - 1)) begin
        st_n = CHECK_PW;
        dcnt_n = '0;
      end else if (!load && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
        st_n = ENTER_ID;
        idc_n = 1'b0;
        dbuf_n = '0;
        dcnt_n = '0;
      end else if (!load) tmr_n = tmr + TW'(1);
      CHECK_PW: begin
        dbuf_n = '0;
        idc_n = 1'b0;
        if (pswd_match) begin
          st_n = LOGGED_IN;
          li_n = 1'b1;
          pid_n = idx;
          fcnt_n = '0;
        end else fail = 1'b1;
      end
      LOGGED_IN: if (bus.logout_req) begin
        st_n = ENTER_ID;
        li_n = 1'b0;
        gst_n = 1'b0;
        pid_n = '0;
        idc_n = 1'b0;
        dbuf_n = '0;
      end
      LOCKED: if (tmr == TW'(LOCK_CYCLES - 1)) begin
        st_n = ENTER_ID;
        lck_n = 1'b0;
        fcnt_n = '0;
      end else tmr_n = tmr + TW'(1);
      default: st_n = ENTER_ID;
    endcase
    // A failure that reaches MAX_TRIES diverts to LOCKED instead of ENTER_ID.
    if (fail) begin
      fcnt_n = fcnt + FCW'(1);
      lck_n = fcnt_n == FCW'(MAX_TRIES);
      st_n = lck_n ? LOCKED : ENTER_ID;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ENTER_ID;
      dbuf <= '0;
      dcnt <= '0;
      tmr <= '0;
      idx <= '0;
      pid <= '0;
      fcnt <= '0;
      li <= 1'b0;
      gst <= 1'b0;
      idc <= 1'b0;
      lck <= 1'b0;
    end else begin
      st <= st_n;
      dbuf <= dbuf_n;
      dcnt <= dcnt_n;
      tmr <= tmr_n;
      idx <= idx_n;
      pid <= pid_n;
      fcnt <= fcnt_n;
      li <= li_n;
      gst <= gst_n;
      idc <= idc_n;
      lck <= lck_n;
    end
  end
  assign bus.logged_in = li;
  assign bus.player_id = pid;
  assign bus.is_guest = gst;
  assign bus.id_correct = idc;
  assign bus.locked_out = lck;
  assign bus.fail_cnt = fcnt;
endmodule

// File: tb/tb_auth_ctrl_param.sv
// tb_auth_ctrl_param: directed login, guest, lockout, timeout, logout and reset scenarios.
module tb_auth_ctrl_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  auth_ctrl_param_if #(.DIGIT_W(4), .PID_W(3), .FAIL_W(2)) bus ();
  auth_ctrl_param #(
    .DIGIT_W(4), .ID_DIGITS(2), .PSWD_DIGITS(4), .NUM_PLAYERS(4), .PID_W(3),
    .MAX_TRIES(3), .LOCK_CYCLES(500), .TIMEOUT_CYCLES(1000)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load_seq(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.user_digit = v[(n-1-i)*4 +: 4];
      bus.user_load = 1'b1;
      @(negedge clk);
      bus.user_load = 1'b0;
    end
  endtask
  task automatic logout();
    @(negedge clk);
    bus.logout_req = 1'b1;
    @(negedge clk);
    bus.logout_req = 1'b0;
    check("logout_li", int'(bus.logged_in), 0);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_li"}, int'(bus.logged_in), 0);
    check({tag, "_pid"}, int'(bus.player_id), 0);
    check({tag, "_guest"}, int'(bus.is_guest), 0);
    check({tag, "_idc"}, int'(bus.id_correct), 0);
    check({tag, "_lock"}, int'(bus.locked_out), 0);
    check({tag, "_fail"}, int'(bus.fail_cnt), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    bus.user_digit = '0;
    bus.user_load = 1'b0;
    bus.logout_req = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    // Player 1 login with latency check on id_correct
    load_seq(2, 16'h0001);
    check("p1_idc_t1", int'(bus.id_correct), 0);
    @(negedge clk);
    check("p1_idc_t2", int'(bus.id_correct), 1);
    load_seq(4, 16'h1234);
    @(negedge clk);
    check("p1_li", int'(bus.logged_in), 1);
    check("p1_pid", int'(bus.player_id), 1);
    check("p1_guest", int'(bus.is_guest), 0);
    check("p1_fail", int'(bus.fail_cnt), 0);
    logout();
    // Guest login
    load_seq(2, 16'h0000);
    check("g_idc_t1", int'(bus.id_correct), 0);
    @(negedge clk);
    check("g_li", int'(bus.logged_in), 1);
    check("g_guest", int'(bus.is_guest), 1);
    check("g_pid", int'(bus.player_id), 0);
    check("g_idc", int'(bus.id_correct), 0);
    logout();
    check("g_out_guest", int'(bus.is_guest), 0);
    // Three wrong passwords for player 2 lead to lockout
    for (int t = 0; t < 3; t++) begin
      load_seq(2, 16'h0002);
      @(negedge clk);
      check("lk_idc", int'(bus.id_correct), 1);
      load_seq(4, 16'h1111);
      @(negedge clk);
      check("lk_idc_clr", int'(bus.id_correct), 0);
      check("lk_fail", int'(bus.fail_cnt), t + 1);
      check("lk_lock", int'(bus.locked_out), t == 2 ? 1 : 0);
    end
    cnt = 1;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (!bus.locked_out) break;
      cnt++;
      bus.user_digit = 4'd1;
      bus.user_load = (cnt % 7 == 0);
    end
    bus.user_load = 1'b0;
    check("lk_cycles", cnt, 500);
    check("lk_fail_clr", int'(bus.fail_cnt), 0);
    check("lk_li", int'(bus.logged_in), 0);
    load_seq(2, 16'h0002);
    @(negedge clk);
    check("lk_after_idc", int'(bus.id_correct), 1);
    load_seq(4, 16'h5678);
    @(negedge clk);
    check("p2_pid", int'(bus.player_id), 2);
    logout();
    // Bad ID counts as a failure; timeout afterwards leaves it alone
    load_seq(2, 16'h0009);
    @(negedge clk);
    check("badid_fail", int'(bus.fail_cnt), 1);
    check("badid_idc", int'(bus.id_correct), 0);
    load_seq(2, 16'h0003);
    load_seq(2, 16'h0090);
    repeat (990) @(negedge clk);
    check("to_before", int'(bus.id_correct), 1);
    repeat (20) @(negedge clk);
    check("to_after", int'(bus.id_correct), 0);
    check("to_fail", int'(bus.fail_cnt), 1);
    load_seq(2, 16'h0003);
    @(negedge clk);
    check("p3_idc", int'(bus.id_correct), 1);
    load_seq(4, 16'h9012);
    @(negedge clk);
    check("p3_li", int'(bus.logged_in), 1);
    check("p3_pid", int'(bus.player_id), 3);
    check("p3_fail", int'(bus.fail_cnt), 0);
    logout();
    // Player 4 logout with a simultaneous digit load
    load_seq(2, 16'h0004);
    load_seq(4, 16'h3456);
    @(negedge clk);
    check("p4_pid", int'(bus.player_id), 4);
    @(negedge clk);
    bus.logout_req = 1'b1;
    bus.user_digit = 4'd0;
    bus.user_load = 1'b1;
    @(negedge clk);
    bus.logout_req = 1'b0;
    bus.user_load = 1'b0;
    check_idle("p4_out");
    load_seq(2, 16'h0001);
    @(negedge clk);
    check("p4_ign_idc", int'(bus.id_correct), 1);
    // Asynchronous reset mid-password
    load_seq(2, 16'h0012);
    #2 rst = 1'b0;
    #1 check("rst_idc", int'(bus.id_correct), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_seq(2, 16'h0001);
    load_seq(4, 16'h1234);
    @(negedge clk);
    check("rst_li", int'(bus.logged_in), 1);
    check("rst_pid", int'(bus.player_id), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
